// File: rtl/consec_seq_pkg.sv
// Shared types and constants for the consecutive-repetition sequence generator.
package consec_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        END  = 2'd2
    } state_e;

    localparam int MIN_LEN = 1;

endpackage

// File: rtl/consec_run_cnt.sv
// Loadable down-counter holding the remaining run length; last_o flags count==1.
module consec_run_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = len_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/consec_seq_gen.sv
// Drives d / a[*L] / b handshake sequences on request.
// Optional embedded assertions and covers: define CONSEC_SEQ_SVA_EN.
module consec_seq_gen
    import consec_seq_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int SEQ_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     len_i,
    input  logic                 abort_i,
    output logic                 d_o,
    output logic                 a_o,
    output logic                 b_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [SEQ_CNT_W-1:0] seq_cnt_o
);

    state_e           state_q;
    logic             last_s;
    logic             load_s;
    logic             dec_s;
    logic [CNT_W-1:0] len_eff_s;

    assign len_eff_s = (len_i == '0) ? CNT_W'(MIN_LEN) : len_i;
    assign load_s    = start_i && ((state_q == IDLE) || (state_q == END));
    // Stop decrementing on the exit edge so last/abort cannot underflow the count.
    assign dec_s     = (state_q == RUN) && !last_s && !abort_i;

    consec_run_cnt #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_s),
        .dec_i  (dec_s),
        .len_i  (len_eff_s),
        .last_o (last_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            d_o       <= 1'b0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            seq_cnt_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    b_o    <= 1'b0;
                    done_o <= 1'b0;
                    if (start_i) begin
                        state_q <= RUN;
                        d_o     <= 1'b1;
                        a_o     <= 1'b1;
                        busy_o  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        d_o     <= 1'b0;
                        a_o     <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                RUN: begin
                    d_o    <= 1'b0;
                    busy_o <= 1'b1;
                    if (last_s || abort_i) begin
                        state_q <= END;
                        a_o     <= 1'b0;
                        b_o     <= 1'b1;
                        done_o  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        a_o     <= 1'b1;
                        b_o     <= 1'b0;
                        done_o  <= 1'b0;
                    end
                end
                END: begin
                    seq_cnt_o <= seq_cnt_o + SEQ_CNT_W'(1);
                    b_o       <= 1'b0;
                    done_o    <= 1'b0;
                    if (start_i) begin
                        state_q <= RUN;
                        d_o     <= 1'b1;
                        a_o     <= 1'b1;
                        busy_o  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        d_o     <= 1'b0;
                        a_o     <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    d_o     <= 1'b0;
                    a_o     <= 1'b0;
                    b_o     <= 1'b0;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONSEC_SEQ_SVA_EN
    a_d_run_b: assert property (@(posedge clk) disable iff (rst)
        d_o |-> a_o [*1:$] ##1 b_o);
    a_b_not_a: assert property (@(posedge clk) disable iff (rst)
        b_o |-> !a_o);
    a_d_after_start: assert property (@(posedge clk) disable iff (rst)
        d_o |-> $past(start_i));
    c_len_one: cover property (@(posedge clk) disable iff (rst)
        d_o ##1 b_o);
    c_len_ge3: cover property (@(posedge clk) disable iff (rst)
        d_o ##1 a_o [*2:$] ##1 b_o);
`endif

endmodule

// File: doc/consec_seq_gen.md
Name: consec_seq_gen

Overview:
- Stimulus generator for the consecutive-repetition handshake: on request it emits trigger `d`, holds `a` high for a programmed run of consecutive cycles, then pulses `b`.
- Every sequence it produces satisfies `@(posedge clk) d |-> a[*1:$] ##1 b`.
- It is the driving end of the sequence our assertion benches check. It is used as a synthesizable traffic source in SVA labs and as a reference driver for the checker.

Parameters:
- CNT_W, 8, width of run-length input and internal down-counter; max run 2**CNT_W-1.
- SEQ_CNT_W, 16, width of completed-sequence counter.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- start_i  input  1  request pulse; sampled on posedge.
- len_i  input  CNT_W  number of consecutive `a` cycles; sampled with start_i; 0 treated as 1.
- abort_i  input  1  truncate current run; sampled on posedge.
- d_o  output  1  trigger, high exactly in first `a` cycle.
- a_o  output  1  repetition signal.
- b_o  output  1  terminating pulse, one cycle.
- busy_o  output  1  high while in RUN or END.
- done_o  output  1  high coincident with b_o.
- seq_cnt_o  output  SEQ_CNT_W  completed sequences, wraps modulo 2**SEQ_CNT_W.

Behaviour:
- All outputs are registered.
- Reset, asynchronous: state=IDLE, counter=0, and d_o, a_o, b_o, busy_o, done_o, seq_cnt_o = 0. Reset mid-sequence drops a_o immediately without b_o. That is the only permitted incomplete sequence.
- States are IDLE, RUN, END.
- IDLE:
  - start_i=1 at edge n → latch L=max(len_i,1), go to RUN.
  - At cycle n+1: d_o=1, a_o=1, busy_o=1, counter=L.
  - Latency from start to d_o is 1 cycle.
- RUN:
  - a_o=1 each cycle; d_o=0 after the first RUN cycle.
  - Counter decrements each cycle.
  - When counter==1 at an edge, or abort_i=1 at an edge, go to END.
  - a_o is therefore high exactly L cycles, or fewer on abort but always ≥1.
- END:
  - b_o=1, done_o=1, a_o=0, d_o=0 for exactly one cycle.
  - seq_cnt_o increments on the edge leaving END.
- END exit:
  - If start_i=1 at the END edge → new sequence; d_o=1 in the cycle right after b_o (back-to-back, no gap).
  - Otherwise → IDLE, busy_o=0.
- start_i in RUN is ignored and does not queue.
- abort_i outside RUN is ignored.
- abort_i in the first RUN cycle gives L_eff=1.
- abort_i coinciding with counter==1 has the same result as a normal finish.
- len_i changes after acceptance have no effect.
- len_i=2**CNT_W-1: a_o high 255 cycles with the default CNT_W, no counter overflow.
- seq_cnt_o wraps from all-ones to 0 silently.

Optional Feature:
- Macro: CONSEC_SEQ_SVA_EN.
- Defined:
  - Embeds concurrent assertion `@(posedge clk) disable iff (rst) d_o |-> a_o[*1:$] ##1 b_o`.
  - Embeds `b_o |-> !a_o`.
  - Embeds `d_o |-> $past(start_i)`.
  - Each has its own labelled assert and a cover for L=1 and L>=3.
- Undefined: no assertion code is compiled and RTL behaviour is identical.

Decomposition:
- Package consec_seq_pkg holds the state enum (IDLE, RUN, END, 2-bit) and localparam MIN_LEN=1.
- One natural sub-module is consec_run_cnt: a loadable down-counter with load, dec, and a last flag (count==1).
- FSM and output registers stay in the top.

Test Plan:
- len_i=4, start_i at cycle 2 → d_o=1 at 3; a_o=1 at 3–6; b_o=1 and done_o=1 at 7; seq_cnt_o=1 at 8; assertion passes.
- len_i=0 → a_o high one cycle, b_o the next cycle; len_i=1 gives identical waveform.
- len_i=10, abort_i at 3rd RUN cycle → a_o high 3 cycles, b_o 4th cycle, busy_o low after.
- Back-to-back: start_i held high, len_i=2 → pattern d/a, a, b, d/a, a, b repeating; no idle cycle; seq_cnt_o counts 1, 2, 3.
- rst asserted mid-RUN (len_i=8, 4th cycle) → all outputs 0 immediately, state IDLE; next start_i gives a normal sequence.
- start_i pulsed during RUN (len_i=5) → ignored; exactly one b_o; seq_cnt_o=1.
